// File: rtl/rx_frame_arbiter_if.sv
// Bundle between the frame arbiter, its two RX buffers and the shared TX buffer.
// The master modport is the arbiter side; slave is the buffer/environment side.
interface rx_frame_arbiter_if #(
   parameter int unsigned LEN_W = 16
) ();
   logic [7:0]       rx0_data;
   logic             rx0_empty;
   logic [LEN_W-1:0] rx0_payload_len;
   logic             rx0_rd_en;
   logic [7:0]       rx1_data;
   logic             rx1_empty;
   logic [LEN_W-1:0] rx1_payload_len;
   logic             rx1_rd_en;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic [LEN_W-1:0] number_of_bytes;
   logic             btx_full;
   logic [1:0]       grant;
   logic             frame_done;

   modport master (
      input  rx0_data, rx0_empty, rx0_payload_len,
      input  rx1_data, rx1_empty, rx1_payload_len,
      input  btx_full,
      output rx0_rd_en, rx1_rd_en,
      output tx_data, tx_valid, number_of_bytes, grant, frame_done
   );

   modport slave (
      output rx0_data, rx0_empty, rx0_payload_len,
      output rx1_data, rx1_empty, rx1_payload_len,
      output btx_full,
      input  rx0_rd_en, rx1_rd_en,
      input  tx_data, tx_valid, number_of_bytes, grant, frame_done
   );
endinterface

// File: rtl/rx_frame_arbiter.sv
// Round-robin, whole-frame arbiter sharing one TX buffer between two RX buffers.
// Grants a source in IDLE, copies its payload byte count in XFER, pulses frame_done in DONE.
module rx_frame_arbiter #(
   parameter int unsigned LEN_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   rx_frame_arbiter_if.master bus_io
);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   localparam logic [LEN_W-1:0] LenOne = {{(LEN_W-1){1'b0}}, 1'b1};

   state_e           state_q;
   logic             rr_q;
   logic             sel_q;
   logic [1:0]       grant_q;
   logic [LEN_W-1:0] nbytes_q;
   logic [LEN_W-1:0] remaining_q;
   logic             tx_valid_q;
   logic             frame_done_q;

   logic             src_empty;
   logic             rd_en;
   logic             any_req;
   logic             pick;
   logic [LEN_W-1:0] pick_len;

   always_comb begin
      src_empty = sel_q ? bus_io.rx1_empty : bus_io.rx0_empty;
      rd_en     = (state_q == StXfer) && !src_empty && !bus_io.btx_full &&
                  (remaining_q != '0);
      any_req   = !bus_io.rx0_empty || !bus_io.rx1_empty;
      // With both requesting follow rr; otherwise take the only one that is non-empty.
      if (!bus_io.rx0_empty && !bus_io.rx1_empty) begin
         pick = rr_q;
      end else begin
         pick = bus_io.rx0_empty;
      end
      pick_len = pick ? bus_io.rx1_payload_len : bus_io.rx0_payload_len;
   end

   assign bus_io.rx0_rd_en       = rd_en && !sel_q;
   assign bus_io.rx1_rd_en       = rd_en && sel_q;
   assign bus_io.tx_data         = sel_q ? bus_io.rx1_data : bus_io.rx0_data;
   assign bus_io.tx_valid        = tx_valid_q;
   assign bus_io.number_of_bytes = nbytes_q;
   assign bus_io.grant           = grant_q;
   assign bus_io.frame_done      = frame_done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         rr_q         <= 1'b0;
         sel_q        <= 1'b0;
         grant_q      <= 2'b00;
         nbytes_q     <= '0;
         remaining_q  <= '0;
         tx_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         tx_valid_q   <= rd_en;
         frame_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  sel_q       <= pick;
                  grant_q     <= pick ? 2'b10 : 2'b01;
                  nbytes_q    <= pick_len;
                  // A zero-length header still moves one byte.
                  remaining_q <= (pick_len == '0) ? LenOne : pick_len;
                  state_q     <= StXfer;
               end
            end
            StXfer: begin
               if (rd_en) begin
                  remaining_q <= remaining_q - LenOne;
                  if (remaining_q == LenOne) begin
                     state_q      <= StDone;
                     frame_done_q <= 1'b1;
                  end
               end
            end
            StDone: begin
               rr_q    <= ~sel_q;
               grant_q <= 2'b00;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_frame_arbiter.sv
// Randomized bench for rx_frame_arbiter: two queue-based RX buffers feed the DUT and a
// frame-level round-robin model predicts the TX byte stream, grants and frame boundaries.
module tb_rx_frame_arbiter;
   localparam int unsigned LEN_W = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rx_frame_arbiter_if #(.LEN_W(LEN_W)) bus ();

   rx_frame_arbiter #(.LEN_W(LEN_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // RX buffer environment
   byte unsigned q0[$];
   byte unsigned q1[$];
   int           lq0[$];
   int           lq1[$];
   int           left0, left1;
   logic         hold0, hold1;
   logic         s_rd0, s_rd1;

   // Reference model: pending frames per source, rr pointer, frame in flight
   byte unsigned mb0[$];
   byte unsigned mb1[$];
   int           ml0[$];
   int           ml1[$];
   bit           m_rr;
   bit           act;
   int           act_src, act_len, act_left, act_seen;
   int           rd_cnt;

   function automatic int nb(input int l);
      return (l == 0) ? 1 : l;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic update_env();
      bus.rx0_empty       = hold0 || (q0.size() == 0);
      bus.rx1_empty       = hold1 || (q1.size() == 0);
      bus.rx0_payload_len = (lq0.size() != 0) ? LEN_W'(lq0[0]) : '0;
      bus.rx1_payload_len = (lq1.size() != 0) ? LEN_W'(lq1[0]) : '0;
   endtask

   task automatic push_frame(input int src, input int len, input int start);
      byte unsigned b;
      for (int i = 0; i < nb(len); i++) begin
         b = (start >= 0) ? 8'(start + i) : 8'($urandom_range(0, 255));
         if (src == 0) begin q0.push_back(b); mb0.push_back(b); end
         else          begin q1.push_back(b); mb1.push_back(b); end
      end
      if (src == 0) begin
         if (lq0.size() == 0) left0 = nb(len);
         lq0.push_back(len); ml0.push_back(len);
      end else begin
         if (lq1.size() == 0) left1 = nb(len);
         lq1.push_back(len); ml1.push_back(len);
      end
      update_env();
   endtask

   task automatic monitor();
      byte unsigned eb;
      bit p0, p1;
      if (bus.tx_valid === 1'b1) begin
         if (!act) begin
            p0 = (ml0.size() != 0);
            p1 = (ml1.size() != 0);
            if (!p0 && !p1) begin
               check("unexpected_tx_valid", 32'(bus.tx_valid), 32'd0);
               return;
            end
            act_src  = (p0 && p1) ? int'(m_rr) : (p1 ? 1 : 0);
            act_len  = (act_src == 1) ? ml1.pop_front() : ml0.pop_front();
            act_left = nb(act_len);
            act_seen = 0;
            act      = 1'b1;
         end
         eb = (act_src == 1) ? mb1.pop_front() : mb0.pop_front();
         check("tx_data", 32'(bus.tx_data), 32'(eb));
         check("grant", 32'(bus.grant), (act_src == 1) ? 32'd2 : 32'd1);
         act_left--;
         act_seen++;
         check("frame_done", 32'(bus.frame_done), 32'(act_left == 0));
         if (act_left == 0) begin
            check("number_of_bytes", 32'(bus.number_of_bytes), 32'(act_len));
            check("rd_pulses", 32'(rd_cnt), 32'(nb(act_len)));
            rd_cnt = 0;
            m_rr   = (act_src == 0);
            act    = 1'b0;
         end
      end else begin
         check("frame_done_idle", 32'(bus.frame_done), 32'd0);
      end
   endtask

   task automatic step();
      #1;
      s_rd0 = bus.rx0_rd_en;
      s_rd1 = bus.rx1_rd_en;
      if (rst_n) begin
         check("rd0_legal", 32'(s_rd0 && (bus.btx_full || bus.rx0_empty || bus.grant !== 2'b01)),
               32'd0);
         check("rd1_legal", 32'(s_rd1 && (bus.btx_full || bus.rx1_empty || bus.grant !== 2'b10)),
               32'd0);
         rd_cnt += int'(s_rd0) + int'(s_rd1);
      end
      @(posedge clk);
      #1;
      if (s_rd0 && q0.size() != 0) begin
         bus.rx0_data = q0.pop_front();
         left0--;
         if (left0 == 0) begin
            void'(lq0.pop_front());
            if (lq0.size() != 0) left0 = nb(lq0[0]);
         end
      end
      if (s_rd1 && q1.size() != 0) begin
         bus.rx1_data = q1.pop_front();
         left1--;
         if (left1 == 0) begin
            void'(lq1.pop_front());
            if (lq1.size() != 0) left1 = nb(lq1[0]);
         end
      end
      update_env();
      @(negedge clk);
      if (rst_n) monitor();
   endtask

   task automatic drain(input int budget, input bit rand_full);
      int n = 0;
      while ((ml0.size() != 0 || ml1.size() != 0 || act) && n < budget) begin
         bus.btx_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
         step();
         n++;
      end
      bus.btx_full = 1'b0;
      check("drain_timeout", 32'(ml0.size() + ml1.size() + int'(act)), 32'd0);
      step();
      step();
   endtask

   task automatic wait_grant(input logic [1:0] exp);
      int n = 0;
      while (bus.grant == 2'b00 && n < 20) begin
         step();
         n++;
      end
      check("grant_seen", 32'(bus.grant), 32'(exp));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      bus.rx0_data = 8'h5A;
      bus.rx1_data = 8'hC3;
      #1;
      check("rst_rd0", 32'(bus.rx0_rd_en), 32'd0);
      check("rst_rd1", 32'(bus.rx1_rd_en), 32'd0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_nbytes", 32'(bus.number_of_bytes), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'h5A);
      q0.delete(); q1.delete(); lq0.delete(); lq1.delete();
      mb0.delete(); mb1.delete(); ml0.delete(); ml1.delete();
      act = 1'b0; m_rr = 1'b0; rd_cnt = 0;
      hold0 = 1'b0; hold1 = 1'b0; bus.btx_full = 1'b0;
      update_env();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n        = 1'b0;
      hold0        = 1'b0;
      hold1        = 1'b0;
      bus.btx_full = 1'b0;
      bus.rx0_data = 8'h00;
      bus.rx1_data = 8'h00;
      left0 = 0; left1 = 0; rd_cnt = 0; act = 1'b0; m_rr = 1'b0;
      act_src = 0; act_len = 0; act_left = 0; act_seen = 0;
      update_env();
      @(negedge clk);
      step();
      do_reset();

      // Single source: A1..A4 on rx0
      push_frame(0, 4, 'hA1);
      wait_grant(2'b01);
      check("single_nbytes", 32'(bus.number_of_bytes), 32'd4);
      drain(40, 1'b0);

      // Contention from reset: expect 0,1,0,1
      do_reset();
      push_frame(0, 3, -1);
      push_frame(1, 2, -1);
      push_frame(0, $urandom_range(1, 5), -1);
      push_frame(1, $urandom_range(1, 5), -1);
      drain(80, 1'b0);

      // Backpressure on XFER cycles 2-4 of a 5-byte frame
      push_frame(0, 5, -1);
      wait_grant(2'b01);
      step();
      bus.btx_full = 1'b1;
      step(); step(); step();
      bus.btx_full = 1'b0;
      drain(40, 1'b0);

      // Underflow stall on rx1; rx0 arrives mid-frame and must wait
      push_frame(1, 6, -1);
      wait_grant(2'b10);
      step(); step();
      hold1 = 1'b1;
      push_frame(0, 3, -1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("sticky_grant", 32'(bus.grant), 32'd2);
      end
      hold1 = 1'b0;
      update_env();
      drain(60, 1'b0);

      // Zero-length headers on both sources
      push_frame(0, 0, -1);
      drain(20, 1'b0);
      push_frame(1, 0, -1);
      drain(20, 1'b0);

      // Randomized rounds with random backpressure
      for (int r = 0; r < 15; r++) begin
         int n0, n1;
         n0 = $urandom_range(0, 3);
         n1 = $urandom_range(0, 3);
         for (int k = 0; k < n0; k++) push_frame(0, $urandom_range(0, 7), -1);
         for (int k = 0; k < n1; k++) push_frame(1, $urandom_range(0, 7), -1);
         drain(400, 1'b1);
      end

      // Reset after 2 of 8 bytes, with rr pointing at source 1 beforehand
      push_frame(0, 1, -1);
      drain(20, 1'b0);
      push_frame(1, 8, -1);
      for (int n = 0; n < 30 && !(act && act_seen >= 2); n++) step();
      check("mid_frame_reached", 32'(act_seen), 32'd2);
      do_reset();
      push_frame(0, 2, -1);
      push_frame(1, 2, -1);
      drain(40, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rx_frame_arbiter.md
# rx_frame_arbiter

Frame-level round-robin arbiter that shares one TX buffer between two RX buffers in the loopback path. It moves whole frames only: it grants one RX buffer, copies exactly that frame's payload byte count into the TX buffer, then re-arbitrates. It drives the RX read enables and the TX write strobe, with `btx_full` as backpressure. The arbiter replaces the single-source pass-through when a second Ethernet RX channel is added.

## Interface
- `LEN_W`, default 16: payload length width; matches the `[1:0][7:0]` length bus.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx0_data`  in  8  RX buffer 0 read data; valid the cycle after `rx0_rd_en`.
- `rx0_empty`  in  1  RX buffer 0 empty.
- `rx0_payload_len`  in  LEN_W  byte count of the frame at the head of buffer 0.
- `rx0_rd_en`  out  1  RX buffer 0 pop.
- `rx1_data`, `rx1_empty`, `rx1_payload_len`, `rx1_rd_en`: same roles for buffer 1.
- `tx_data`  out  8  byte to the TX buffer.
- `tx_valid`  out  1  TX write strobe.
- `number_of_bytes`  out  LEN_W  length of the frame being transferred.
- `btx_full`  in  1  TX buffer full.
- `grant`  out  2  one-hot active source; `2'b00` when idle.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame is written.

## Operation
- States: IDLE, XFER, DONE. Reset enters IDLE.
- **Round-robin pointer `rr`** (1 bit): selects the preferred source. Reset value is 0 (source 0 preferred).
- **IDLE:**
  - If exactly one `rxN_empty` is low, select that source.
  - If both are low, select source `rr`.
  - On selection, register:
    - `sel`.
    - `grant`, one-hot.
    - `number_of_bytes <= rxN_payload_len`.
    - `remaining <= rxN_payload_len`, except that 0 loads as 1 (clamp).
  - Then go to XFER.
  - No read is issued in IDLE.
- **XFER:**
  - Read enable (combinational): `rx<sel>_rd_en = !rx<sel>_empty && !btx_full && (remaining != 0)`.
  - The non-selected read enable is 0.
  - Each asserted read decrements `remaining`.
  - A read issued with `remaining == 1` moves the state to DONE.
  - Empty and full stall the transfer without limit; there is no timeout.
- **DONE:**
  - Lasts one cycle. The last byte's `tx_valid` is high here.
  - Pulse `frame_done`.
  - Set `rr <= ~sel`.
  - Clear `grant`.
  - Return to IDLE.
- **Output path:**
  - `tx_valid <= rx0_rd_en | rx1_rd_en`, registered.
  - `tx_data = rx<sel>_data` (combinational mux). `sel` is held through DONE, so the mux stays on the correct source.
- `number_of_bytes` holds its value from the grant until the next grant.
- **Reset mid-frame:**
  - State returns to IDLE.
  - `rr` = 0.
  - All outputs take their reset values.
  - Any partial frame already in the TX buffer is left as is. Upstream reset handles the buffers.

## Timing
- **Reset values:**
  - `rx0_rd_en`, `rx1_rd_en` = 0.
  - `tx_valid` = 0.
  - `tx_data` = `rx0_data` (since `sel` = 0).
  - `number_of_bytes` = 0.
  - `grant` = 00.
  - `frame_done` = 0.
- **Latency:**
  - Non-empty seen in IDLE at cycle T gives `grant` at T+1.
  - The first `rd_en` can be at T+1.
  - The first `tx_valid` is at T+2.
- **Throughput:** one byte per cycle with no stall. An L-byte frame takes L+2 cycles from grant to the next IDLE.
- **Reads are gated by same-cycle signals:**
  - `btx_full` sampled in cycle C blocks the read in C.
  - Because `tx_valid` lags the read by one cycle, the TX buffer must accept one write after it asserts full.
- Minimum gap between frames: 2 cycles (DONE, then IDLE).
- `frame_done` is coincident with the final `tx_valid`.

## Test plan
- **Single source:**
  - Stimulus: `rx0` holds a 4-byte frame A1..A4 with `payload_len` = 4; `btx_full` = 0.
  - Required response:
    - `grant` = 01.
    - 4 consecutive `tx_valid` carrying A1..A4.
    - `number_of_bytes` = 4.
    - `frame_done` on the 4th byte.
    - Exactly 4 `rx0_rd_en` pulses.
- **Contention:**
  - Stimulus: both sources hold frames (len 3 and len 2) from reset.
  - Required response:
    - Source 0 is served first, then source 1.
    - Next-pair order is 0 then 1 again after `rr` toggles.
    - No interleaving of bytes between frames.
- **Backpressure:**
  - Stimulus: len-5 frame, `btx_full` high for cycles 2–4 of XFER.
  - Required response:
    - `rd_en` = 0 during those cycles.
    - 5 bytes total, order preserved.
    - `frame_done` only after the 5th byte.
- **Underflow stall:**
  - Stimulus: `rx1_empty` toggles mid-frame (len 6).
  - Required response:
    - Reads pause while empty.
    - The arbiter stays granted to source 1 even if `rx0` becomes non-empty.
- **Zero length:**
  - Stimulus: `payload_len` = 0.
  - Required response:
    - Exactly 1 byte is transferred.
    - `number_of_bytes` = 0.
    - `frame_done` is pulsed.
- **Reset mid-frame:**
  - Stimulus: `rst_n` low after 2 of 8 bytes.
  - Required response:
    - The next cycle shows all outputs at their reset values and `grant` = 00.
    - After release, a fresh arbitration prefers source 0.
